axi_rd_responder: RTL and testbench

- AXI4 read-channel slave (subordinate) with a synchronous on-chip memory array behind it.
- Answers the core's AR/R master port: it accepts one address request, waits a programmable latency, then streams RLEN+1 beats with RLAST.
- Serves as the bench/FPGA memory model for instruction and load fetches, replacing the DPI read path.
- Has a side write port used for image preload and for the core's store path.

---
 rtl/axi_rd_responder_pkg.sv | 24 ++
 rtl/axi_rd_responder_if.sv | 35 +++
 rtl/axi_rd_responder_addr_gen.sv | 42 ++++
 rtl/axi_rd_responder.sv | 182 ++++++++++++++++++
 tb/tb_axi_rd_responder.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_responder_pkg.sv
// Shared definitions for the AXI4 read responder.
// Holds the AXI burst/response encodings, the responder FSM state type
// and a helper that recognises the legal WRAP burst lengths.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } state_t;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read address (AR) and read data (R) channel bundle.
// Ports (signal members):
//   AR: ARID[3:0] ARADDR[63:0] ARLEN[7:0] ARSIZE[2:0] ARBURST[1:0]
//       ARPORT[2:0] ARVALID ARREADY
//   R : RID[3:0] RDATA[63:0] RRESP[1:0] RLAST RVALID RREADY
// Modports: master (issues AR, consumes R), slave (the responder).
interface axi_rd_responder_if;

    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [2:0]  ARPORT;
    logic        ARVALID;
    logic        ARREADY;

    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPORT, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPORT, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/axi_rd_responder_addr_gen.sv
// axi_burst_addr_gen: combinational AXI burst address step.
// Ports:
//   addr       in  current beat byte address
//   len        in  ARLEN (beats minus 1)
//   size       in  ARSIZE (log2 bytes per beat)
//   burst      in  ARBURST
//   next_addr  out address of the following beat
//   wrap_lower out lower wrap boundary (addr aligned to the wrap span)
//   burst_err  out burst is unsupported (size > 8 bytes or illegal WRAP length)
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [63:0] next_addr,
    output logic [63:0] wrap_lower,
    output logic        burst_err
);

    logic [63:0] bytes;
    logic [63:0] wrap_bytes;
    logic [63:0] inc_addr;

    always_comb begin
        bytes      = 64'd1 << size;
        wrap_bytes = ({56'd0, len} + 64'd1) << size;
        // Only meaningful when wrap_bytes is a power of two; other spans are flagged by burst_err.
        wrap_lower = addr & ~(wrap_bytes - 64'd1);
        inc_addr   = addr + bytes;

        case (burst)
            BURST_INCR: next_addr = inc_addr;
            BURST_WRAP: next_addr = (inc_addr == wrap_lower + wrap_bytes) ? wrap_lower : inc_addr;
            default:    next_addr = addr;
        endcase

        burst_err = (size > 3'd3) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
    end

endmodule

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI4 read-channel slave backed by an on-chip 64-bit memory.
// Accepts one AR request at a time, waits RD_LATENCY cycles, then streams
// ARLEN+1 beats with RLAST. A side write port (byte strobes) preloads or
// updates the array; reads see a same-cycle write only on the following beat.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             AR/R channels (slave modport)
//   mem_we          side write enable
//   mem_waddr       side write byte address
//   mem_wdata       side write data
//   mem_wstrb       side write byte strobes
// Optional macro AXI_RD_RANDOM_STALL_EN: LFSR-driven one-cycle RVALID bubbles.
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 65536,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_rd_responder_if.slave    bus,
    input  logic                 mem_we,
    input  logic [63:0]          mem_waddr,
    input  logic [63:0]          mem_wdata,
    input  logic [7:0]           mem_wstrb
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    logic [63:0] mem [MEM_WORDS];

    state_t      state;
    logic [3:0]  id_q;
    logic [63:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [CW-1:0] cnt_q;
    logic        arready_q;
    logic        rvalid_q;
    logic        rlast_q;
    logic [63:0] rdata_q;
    logic [1:0]  rresp_q;

    logic [63:0] next_addr;
    logic [63:0] wrap_lower;
    logic        burst_err;
    logic        handshake;
    logic        stall;

    axi_burst_addr_gen u_addr_gen (
        .addr       (addr_q),
        .len        (len_q),
        .size       (size_q),
        .burst      (burst_q),
        .next_addr  (next_addr),
        .wrap_lower (wrap_lower),
        .burst_err  (burst_err)
    );

    // The first beat reads the latched start address; later beats read ahead at next_addr.
    logic [63:0] rd_addr, rd_off, rd_word, rd_data;
    logic        rd_ok;
    logic [1:0]  rd_resp;
    logic [63:0] wr_off, wr_word;
    logic        wr_ok;

    always_comb begin
        rd_addr = (state == BEAT) ? next_addr : addr_q;
        rd_off  = rd_addr - BASE_ADDR;
        rd_word = rd_off >> 3;
        rd_ok   = (rd_addr >= BASE_ADDR) && (rd_word < 64'(MEM_WORDS)) && !burst_err;
        rd_data = rd_ok ? mem[rd_word[AW-1:0]] : '0;
        rd_resp = rd_ok ? RESP_OKAY : RESP_SLVERR;

        wr_off  = mem_waddr - BASE_ADDR;
        wr_word = wr_off >> 3;
        wr_ok   = (mem_waddr >= BASE_ADDR) && (wr_word < 64'(MEM_WORDS));
    end

    assign handshake = bus.ARVALID & arready_q;

`ifdef AXI_RD_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            id_q      <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Registered ready: rises one cycle after reset or burst completion.
                    arready_q <= !handshake;
                    if (handshake) begin
                        id_q    <= bus.ARID;
                        addr_q  <= bus.ARADDR;
                        len_q   <= bus.ARLEN;
                        size_q  <= bus.ARSIZE;
                        burst_q <= bus.ARBURST;
                        cnt_q   <= CW'(RD_LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q  <= rd_data;
                        rresp_q  <= rd_resp;
                        beat_q   <= '0;
                        rlast_q  <= (len_q == 8'd0);
                        rvalid_q <= !stall;
                        state    <= BEAT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BEAT: begin
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                    end else if (bus.RREADY) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            addr_q   <= next_addr;
                            beat_q   <= beat_q + 8'd1;
                            rlast_q  <= (beat_q + 8'd1 == len_q);
                            rdata_q  <= rd_data;
                            rresp_q  <= rd_resp;
                            rvalid_q <= !stall;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && wr_ok) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (mem_wstrb[b]) mem[wr_word[AW-1:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RLAST   = rlast_q;
    assign bus.RID     = id_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

    logic unused_ok;
    assign unused_ok = ^{bus.ARPORT, wrap_lower};

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: table of read bursts with
// hand-derived word orders, scoreboard of expected beats, plus sequences for
// read-before-write, busy hold-off, mid-burst reset and byte strobes.
module tb_axi_rd_responder;
    import axi_pkg::*;

    localparam int unsigned MW   = 1024;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [63:0] mem_waddr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_wstrb = '0;

    axi_rd_responder_if bus();

    axi_rd_responder #(
        .MEM_WORDS  (MW),
        .BASE_ADDR  (BASE),
        .RD_LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        bit          toggle;
        int          w0, w1, w2, w3;   // expected word per beat, -1 = SLVERR
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    hs_cyc = 0;
    int    rlast_cyc = 0;
    bit    first_seen = 1'b1;
    bit    mon_en = 1'b0;
    bit    rr_toggle = 1'b0;
    beat_t sb[$];
    logic [63:0] model [MW];
    vec_t  vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        beat_t b;
        b.data = d; b.resp = r; b.last = l; b.id = id;
        sb.push_back(b);
    endtask

    task automatic push_word(input int w, input logic l, input logic [3:0] id);
        if (w < 0) push_beat(64'd0, RESP_SLVERR, l, id);
        else       push_beat(model[w], RESP_OKAY, l, id);
    endtask

    task automatic side_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int idx;
        @(posedge clk); #1;
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d; mem_wstrb = s;
        @(posedge clk); #1;
        mem_we = 1'b0;
        if (a >= BASE && ((a - BASE) >> 3) < 64'(MW)) begin
            idx = int'((a - BASE) >> 3);
            for (int b = 0; b < 8; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [1:0] bt, input logic [3:0] id);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.ARADDR = a; bus.ARLEN = l; bus.ARSIZE = s; bus.ARBURST = bt; bus.ARID = id;
        bus.ARVALID = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.ARREADY === 1'b1) begin
                ok = 1'b1;
                hs_cyc = cyc + 1;
                first_seen = 1'b0;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ar_handshake: got no ARREADY in 50 cycles, need handshake");
        end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d beats still pending, need 0", sb.size());
            sb.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.RREADY = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.RREADY = rr_toggle ? ~bus.RREADY : 1'b1;
        end
    end

    // Monitor: compares accepted beats against the scoreboard, checks that a
    // stalled beat is held, and measures first-beat latency.
    initial begin : monitor
        beat_t e;
        bit pst;
        logic [63:0] pd;
        logic [1:0]  pr;
        logic        pl;
        logic [3:0]  pi;
        pst = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                pst = 1'b0;
            end else begin
                if (pst) begin
                    checks++;
                    if (!(bus.RVALID === 1'b1 && bus.RDATA === pd && bus.RRESP === pr &&
                          bus.RLAST === pl && bus.RID === pi)) begin
                        errors++;
                        $display("FAIL hold: got valid=%b data=%h resp=%b last=%b id=%h, need valid=1 data=%h resp=%b last=%b id=%h",
                                 bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST, bus.RID, pd, pr, pl, pi);
                    end
                end
                if (bus.RVALID === 1'b1 && !first_seen) begin
                    first_seen = 1'b1;
`ifndef AXI_RD_RANDOM_STALL_EN
                    check("first_latency", 64'(cyc - hs_cyc), 64'd2);
`endif
                end
                if (bus.RVALID === 1'b1 && bus.RREADY === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got data=%h id=%h, need no beat", bus.RDATA, bus.RID);
                    end else begin
                        e = sb.pop_front();
                        if (bus.RDATA !== e.data || bus.RRESP !== e.resp || bus.RLAST !== e.last || bus.RID !== e.id) begin
                            errors++;
                            $display("FAIL beat: got data=%h resp=%b last=%b id=%h, need data=%h resp=%b last=%b id=%h",
                                     bus.RDATA, bus.RRESP, bus.RLAST, bus.RID, e.data, e.resp, e.last, e.id);
                        end
                    end
                    if (bus.RLAST === 1'b1) rlast_cyc = cyc + 1;
                end
                pst = (bus.RVALID === 1'b1) && (bus.RREADY !== 1'b1);
                pd = bus.RDATA; pr = bus.RRESP; pl = bus.RLAST; pi = bus.RID;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200us, need finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : main
        int ws[4];
        bit ok;
        logic [63:0] old9;

        vecs[0]  = '{64'h8000_0008, 8'd0, 3'd3, BURST_INCR,  4'd5,  1'b0, 1, 0, 0, 0};
        vecs[1]  = '{64'h8000_0000, 8'd3, 3'd3, BURST_INCR,  4'd1,  1'b1, 0, 1, 2, 3};
        vecs[2]  = '{64'h8000_0010, 8'd3, 3'd3, BURST_WRAP,  4'd2,  1'b0, 2, 3, 0, 1};
        vecs[3]  = '{64'h7FFF_FFF8, 8'd1, 3'd3, BURST_INCR,  4'd3,  1'b0, -1, 0, 0, 0};
        vecs[4]  = '{64'h8000_0018, 8'd2, 3'd3, BURST_FIXED, 4'd4,  1'b1, 3, 3, 3, 0};
        vecs[5]  = '{64'h8000_1FF8, 8'd1, 3'd3, BURST_INCR,  4'd6,  1'b0, 1023, -1, 0, 0};
        vecs[6]  = '{64'h8000_0000, 8'd1, 3'd4, BURST_INCR,  4'd7,  1'b0, -1, -1, 0, 0};
        vecs[7]  = '{64'h8000_0000, 8'd2, 3'd3, BURST_WRAP,  4'd8,  1'b0, -1, -1, -1, 0};
        vecs[8]  = '{64'h8000_0004, 8'd3, 3'd2, BURST_INCR,  4'd9,  1'b1, 0, 1, 1, 2};
        vecs[9]  = '{64'h8000_0028, 8'd1, 3'd3, BURST_WRAP,  4'd10, 1'b0, 5, 4, 0, 0};
        vecs[10] = '{64'h8000_000C, 8'd3, 3'd2, BURST_WRAP,  4'd11, 1'b0, 1, 0, 0, 1};

        bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
        bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARPORT = 3'b010;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 64'(bus.ARREADY), 64'd0);
        check("rst_rvalid",  64'(bus.RVALID),  64'd0);
        check("rst_rlast",   64'(bus.RLAST),   64'd0);
        check("rst_rid",     64'(bus.RID),     64'd0);
        check("rst_rdata",   bus.RDATA,        64'd0);
        check("rst_rresp",   64'(bus.RRESP),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++)
            side_write(BASE + 64'(i * 8), {32'hC0DE_0000 | 32'(i), 32'h0BAD_0000 | 32'(i)}, 8'hFF);
        side_write(BASE + 64'h8, 64'h1122_3344_5566_7788, 8'hFF);
        side_write(BASE + 64'(1023 * 8), 64'hFEED_FACE_CAFE_F00D, 8'hFF);
        // Out-of-range writes must be dropped (the upper one would alias word 0 if not).
        side_write(BASE - 64'd8, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
        side_write(BASE + 64'(MW * 8), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);

        for (int i = 0; i < 11; i++) begin
            ws[0] = vecs[i].w0; ws[1] = vecs[i].w1; ws[2] = vecs[i].w2; ws[3] = vecs[i].w3;
            rr_toggle = vecs[i].toggle;
            for (int b = 0; b <= int'(vecs[i].len); b++)
                push_word(ws[b], b == int'(vecs[i].len), vecs[i].id);
            send(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].id);
            wait_drain();
        end
        rr_toggle = 1'b0;

        // Read-before-write: write word 9 on the edge that accepts beat 0 of a FIXED burst.
        old9 = model[9];
        push_beat(old9, RESP_OKAY, 1'b0, 4'd12);
        push_beat(old9, RESP_OKAY, 1'b0, 4'd12);
        push_beat(64'h5555_AAAA_5555_AAAA, RESP_OKAY, 1'b1, 4'd12);
        send(BASE + 64'h48, 8'd2, 3'd3, BURST_FIXED, 4'd12);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.RVALID === 1'b1) ok = 1'b1;
        end
        check("rbw_first_beat_seen", 64'(ok), 64'd1);
        mem_we = 1'b1; mem_waddr = BASE + 64'h48; mem_wdata = 64'h5555_AAAA_5555_AAAA; mem_wstrb = 8'hFF;
        @(posedge clk); #1;
        mem_we = 1'b0;
        model[9] = 64'h5555_AAAA_5555_AAAA;
        wait_drain();

        // Busy hold-off: second request waits until one cycle after the RLAST handshake.
        rr_toggle = 1'b1;
        for (int b = 0; b < 4; b++) push_word(b, b == 3, 4'd13);
        push_word(4, 1'b1, 4'd14);
        send(BASE, 8'd3, 3'd3, BURST_INCR, 4'd13);
        bus.ARADDR = BASE + 64'h20; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd3;
        bus.ARBURST = BURST_INCR; bus.ARID = 4'd14; bus.ARVALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.ARREADY === 1'b1) ok = 1'b1;
        end
        check("busy_arready_seen", 64'(ok), 64'd1);
        check("busy_pending_beats", 64'(sb.size()), 64'd1);
        check("busy_arready_rise", 64'(cyc), 64'(rlast_cyc + 1));
        hs_cyc = cyc + 1;
        first_seen = 1'b0;
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        wait_drain();
        rr_toggle = 1'b0;

        // Reset mid-burst: burst abandoned, ready returns one cycle after reset.
        mon_en = 1'b0;
        send(BASE, 8'd3, 3'd3, BURST_INCR, 4'd15);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.RVALID === 1'b1) ok = 1'b1;
        end
        check("rst_mid_burst_active", 64'(ok), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rvalid",  64'(bus.RVALID),  64'd0);
        check("rst_mid_arready", 64'(bus.ARREADY), 64'd0);
        @(negedge clk);
        check("rst_mid_arready_rise", 64'(bus.ARREADY), 64'd1);
        first_seen = 1'b1;
        mon_en = 1'b1;

        // Byte strobes: low four lanes written into a zeroed word.
        side_write(BASE + 64'h10, 64'd0, 8'hFF);
        side_write(BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        push_beat(64'h0000_0000_FFFF_FFFF, RESP_OKAY, 1'b1, 4'd3);
        send(BASE + 64'h10, 8'd0, 3'd3, BURST_INCR, 4'd3);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
